// File: rtl/inst_packer.sv
// Packs decoded instruction fields into PE instruction words and streams them out
// through a small FIFO with sequential write addresses. Optional macro: INST_PACKER_CANON_EN.
module inst_packer #(
  parameter int fnLen          = 3,
  parameter int nameLen        = 3,
  parameter int indexLen       = 8,
  parameter int weightAddrLen  = 5,
  parameter int interimAddrLen = 2,
  parameter int peBusIndexLen  = 4,
  parameter int gbBusIndexLen  = 4,
  parameter int memAddrLen     = 8,
  parameter int fifoDepth      = 4,
  parameter int instLen        = fnLen + 2*(indexLen+nameLen) + 1 + interimAddrLen + 1
                                 + weightAddrLen + 1 + 1 + peBusIndexLen + gbBusIndexLen
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [memAddrLen-1:0]      base_addr,
  input  logic [memAddrLen:0]        num_inst,
  input  logic                       fld_valid,
  output logic                       fld_ready,
  input  logic [fnLen-1:0]           fn,
  input  logic [nameLen-1:0]         src0Name,
  input  logic [nameLen-1:0]         src1Name,
  input  logic [indexLen-1:0]        src0Index,
  input  logic [indexLen-1:0]        src1Index,
  input  logic                       dest_interim_wrt,
  input  logic [interimAddrLen-1:0]  dest_interim_Index,
  input  logic                       dest_weight_wrt,
  input  logic [weightAddrLen-1:0]   dest_weight_Index,
  input  logic                       dest_pu_neigh_wrt,
  input  logic                       dest_pe_neigh_wrt,
  input  logic                       dest_pe_bus_wrt,
  input  logic [peBusIndexLen-2:0]   dest_pe_bus_Index,
  input  logic                       dest_gb_bus_wrt,
  input  logic [gbBusIndexLen-2:0]   dest_gb_bus_Index,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [instLen-1:0]         inst_word,
  output logic [memAddrLen-1:0]      inst_addr,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(fifoDepth);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [memAddrLen:0]   CNT_ONE  = 1;
  localparam logic [memAddrLen-1:0] ADDR_ONE = 1;
  localparam logic [AW:0]           PTR_ONE  = 1;

  logic [1:0]            state;
  logic [memAddrLen:0]   num_q, acc_cnt, sent_cnt;
  logic [memAddrLen-1:0] addr_q;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [instLen-1:0]    mem [fifoDepth];
  logic                  empty, full, push, pop;
  logic [instLen-1:0]    packed_word;

  logic [interimAddrLen-1:0] ii;
  logic [weightAddrLen-1:0]  wi;
  logic [peBusIndexLen-2:0]  pbi;
  logic [gbBusIndexLen-2:0]  gbi;

`ifdef INST_PACKER_CANON_EN
  // Unused dest indices are zeroed so equivalent operations encode identically.
  assign ii  = dest_interim_wrt ? dest_interim_Index : '0;
  assign wi  = dest_weight_wrt  ? dest_weight_Index  : '0;
  assign pbi = dest_pe_bus_wrt  ? dest_pe_bus_Index  : '0;
  assign gbi = dest_gb_bus_wrt  ? dest_gb_bus_Index  : '0;
`else
  assign ii  = dest_interim_Index;
  assign wi  = dest_weight_Index;
  assign pbi = dest_pe_bus_Index;
  assign gbi = dest_gb_bus_Index;
`endif

  assign packed_word = {fn, src0Name, src0Index, src1Name, src1Index,
                        dest_interim_wrt, ii, dest_weight_wrt, wi,
                        dest_pu_neigh_wrt, dest_pe_neigh_wrt,
                        dest_pe_bus_wrt, pbi, dest_gb_bus_wrt, gbi};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // full comes from registered pointers, so a same-cycle pop never enables a push
  assign fld_ready  = (state == S_LOAD) && !full && (acc_cnt < num_q);
  assign push       = fld_valid && fld_ready;
  assign inst_valid = !empty;
  assign pop        = inst_valid && inst_ready;
  assign inst_word  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign inst_addr  = addr_q;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= packed_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      num_q    <= '0;
      acc_cnt  <= '0;
      sent_cnt <= '0;
      addr_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        acc_cnt <= acc_cnt + CNT_ONE;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        sent_cnt <= sent_cnt + CNT_ONE;
        addr_q   <= addr_q + ADDR_ONE;
      end
      case (state)
        S_IDLE: if (start) begin
          num_q    <= num_inst;
          addr_q   <= base_addr;
          acc_cnt  <= '0;
          sent_cnt <= '0;
          state    <= S_LOAD;
        end
        S_LOAD:  if (acc_cnt == num_q) state <= S_DRAIN;
        S_DRAIN: if (empty && (sent_cnt == num_q)) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_packer.sv
// Randomized bench for inst_packer: a queue-based model of accepted words and
// addresses is compared with the DUT outputs on every cycle.
module tb_inst_packer;
  typedef struct packed {
    logic [2:0] fn;  logic [2:0] s0n; logic [7:0] s0i; logic [2:0] s1n; logic [7:0] s1i;
    logic iw; logic [1:0] ii; logic ww; logic [4:0] wi; logic pu; logic pe;
    logic pbw; logic [2:0] pbi; logic gbw; logic [2:0] gbi;
  } fld_t;

  logic clk = 0, reset = 1, start = 0, fld_valid = 0, inst_ready = 0;
  logic [7:0] base_addr = '0;
  logic [8:0] num_inst = '0;
  fld_t cur = '0;
  logic fld_ready, inst_valid, busy, done;
  logic [43:0] inst_word;
  logic [7:0] inst_addr;

  inst_packer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_inst(num_inst),
    .fld_valid(fld_valid), .fld_ready(fld_ready), .fn(cur.fn),
    .src0Name(cur.s0n), .src1Name(cur.s1n), .src0Index(cur.s0i), .src1Index(cur.s1i),
    .dest_interim_wrt(cur.iw), .dest_interim_Index(cur.ii),
    .dest_weight_wrt(cur.ww), .dest_weight_Index(cur.wi),
    .dest_pu_neigh_wrt(cur.pu), .dest_pe_neigh_wrt(cur.pe),
    .dest_pe_bus_wrt(cur.pbw), .dest_pe_bus_Index(cur.pbi),
    .dest_gb_bus_wrt(cur.gbw), .dest_gb_bus_Index(cur.gbi),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word),
    .inst_addr(inst_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int rdy_mode = 1;
  fld_t fq [16];

  // model state
  logic [43:0] exp_q [$];
  logic [7:0]  addr_log [$];
  logic [7:0]  exp_addr, last_addr;
  logic [43:0] last_word;
  int num_exp, sent, acc, start_cyc, done_cyc, last_hs;
  bit active = 0, rst_seen = 0, prev_start = 0, after_done = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic fld_t canon(input fld_t f);
    fld_t g = f;
`ifdef INST_PACKER_CANON_EN
    if (!g.iw)  g.ii  = '0;
    if (!g.ww)  g.wi  = '0;
    if (!g.pbw) g.pbi = '0;
    if (!g.gbw) g.gbi = '0;
`endif
    return g;
  endfunction

  function automatic fld_t rand_fld();
    logic [63:0] r = {$urandom(), $urandom()};
    return r[43:0];
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    int outstanding;
    if (reset) begin
      exp_q.delete(); active = 0; rst_seen = 1; prev_start = 0; after_done = 0;
    end else begin
      if (rst_seen) begin
        check("rst_fld_ready", fld_ready, 0);  check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_word", inst_word, 0);  check("rst_inst_addr", inst_addr, 0);
        check("rst_busy", busy, 0);            check("rst_done", done, 0);
        rst_seen = 0;
      end
      if (prev_start) check("busy_after_start", busy, 1);
      outstanding = exp_q.size();
      check("valid_vs_model", inst_valid, outstanding != 0);
      if (inst_valid && outstanding != 0) begin
        check("word", inst_word, exp_q[0]);
        check("addr", inst_addr, exp_addr);
        last_word = inst_word; last_addr = inst_addr;
        if (inst_ready) begin
          void'(exp_q.pop_front());
          addr_log.push_back(inst_addr);
          exp_addr++; sent++; last_hs = cyc;
        end
      end
      if (fld_ready)
        check("fld_ready_legal", active && acc < num_exp && outstanding < 4, 1);
      if (fld_valid && fld_ready) begin
        exp_q.push_back(canon(cur)); acc++;
      end
      if (done) begin
        check("done_expected", active, 1);
        check("done_sent", sent, num_exp);
        if (num_exp == 0) check("done_lat_empty", cyc - start_cyc, 3);
        else              check("done_lat", cyc - last_hs, 2);
        done_cyc = cyc; active = 0; after_done = 1;
      end else if (after_done) begin
        check("idle_after_done", busy, 0); after_done = 0;
      end
      prev_start = start && !busy;
      if (start && !busy) begin
        active = 1; num_exp = num_inst; exp_addr = base_addr;
        sent = 0; acc = 0; start_cyc = cyc;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       inst_ready = 0;
        1:       inst_ready = 1;
        default: inst_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // all tasks enter and leave at posedge+1
  task automatic start_prog(input logic [7:0] b, input int n);
    start = 1; base_addr = b; num_inst = 9'(n);
    @(posedge clk); #1; start = 0;
  endtask

  task automatic drive_fields(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      cur = fq[i]; fld_valid = 1;
      do begin @(negedge clk); t++; end while (!fld_ready && t < 300);
      if (!fld_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1; fld_valid = 0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 500);
    if (!done) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] e;
    repeat (3) @(posedge clk); #1; reset = 0;
    @(posedge clk); #1;

    // basic packing: fn in the MSBs
    rdy_mode = 1;
    fq[0] = '0; fq[0].fn = 3'b101;
    start_prog(8'h10, 1); drive_fields(1, 0); wait_done();
    check("lit_word_fn", last_word, 44'hA0000000000);
    check("lit_addr", last_addr, 8'h10);
    check("lit_done_delay", done_cyc - last_hs, 2);

    // GB bus field in the LSBs
    fq[0] = '0; fq[0].gbw = 1; fq[0].gbi = 3'b101;
    start_prog(8'h00, 1); drive_fields(1, 0); wait_done();
    check("lit_gb_bus", last_word[3:0], 4'hD);

    // index with wrt low
    fq[0] = '0; fq[0].gbi = 3'b101;
    start_prog(8'h00, 1); drive_fields(1, 0); wait_done();
`ifdef INST_PACKER_CANON_EN
    check("lit_canon", last_word[3:0], 4'h0);
`else
    check("lit_canon", last_word[3:0], 4'h5);
`endif

    // sustained throughput: start T, last handshake T+9, done T+11
    for (int i = 0; i < 8; i++) fq[i] = rand_fld();
    start_prog(8'h80, 8); drive_fields(8, 0); wait_done();
    check("lit_throughput", done_cyc - start_cyc, 11);

    // backpressure and address wrap
    rdy_mode = 0; addr_log.delete();
    for (int i = 0; i < 6; i++) fq[i] = rand_fld();
    start_prog(8'hFE, 6);
    fork
      drive_fields(6, 0);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_accepts", acc, 4);
        check("bp_fld_ready", fld_ready, 0);
        rdy_mode = 1;
      end
    join
    wait_done();
    check("bp_count", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
      e = 8'hFE + 8'(i);
      check("bp_addr_seq", addr_log[i], e);
    end

    // empty program
    start_prog(8'h40, 0);
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin n++; @(negedge clk); end
    check("empty_busy_len", n, 3);
    @(posedge clk); #1;
    check("empty_done_at", done_cyc - start_cyc, 3);

    // reset mid-load
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) fq[i] = rand_fld();
    start_prog(8'h20, 5); drive_fields(2, 0);
    reset = 1; @(posedge clk); #1; reset = 0;
    @(negedge clk);
    check("rst_mid_valid", inst_valid, 0);
    check("rst_mid_busy", busy, 0);
    @(posedge clk); #1;
    rdy_mode = 2; addr_log.delete();
    for (int i = 0; i < 3; i++) fq[i] = rand_fld();
    start_prog(8'h30, 3); drive_fields(3, 1); wait_done();
    check("post_rst_first_addr", addr_log.size() > 0 ? addr_log[0] : 8'hxx, 8'h30);

    // random programs; one includes an ignored start pulse while busy
    for (int p = 0; p < 20; p++) begin
      int k = $urandom_range(1, 12);
      for (int i = 0; i < k; i++) fq[i] = rand_fld();
      rdy_mode = 2;
      start_prog(8'($urandom), k);
      if (p == 5) begin
        start = 1; base_addr = 8'h55; num_inst = 9'd3;
        @(posedge clk); #1; start = 0;
      end
      drive_fields(k, 1); wait_done();
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
